// File: rtl/masked_sbox_seq.sv
// Sequencer for the three-share masked AES S-box pipeline: request handshake,
// 2-entry fresh-randomness FIFO, global stage enable and stage-aligned randomness.
// Optional eval_cnt output is built when MASKED_SBOX_SEQ_CNT_EN is defined.
module masked_sbox_seq #(
    parameter int LAT    = 4,
    parameter int RSTAGE = 1,
    parameter int RND_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [RND_W-1:0] rnd_in,
    input  logic             rnd_valid,
    output logic             rnd_ready,
    output logic             sbox_en,
    output logic [RND_W-1:0] sbox_r,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             flush,
    output logic             done,
    output logic             busy
`ifdef MASKED_SBOX_SEQ_CNT_EN
    ,
    output logic [15:0]      eval_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LAT-1:0]   v_q, v_d;
    logic [RND_W-1:0] rp_q [RSTAGE];
    logic [RND_W-1:0] rp_d [RSTAGE];
    logic [RND_W-1:0] fifo_mem_q [2];
    logic [RND_W-1:0] fifo_mem_d [2];
    logic             fifo_rd_q, fifo_rd_d;
    logic             fifo_wr_q, fifo_wr_d;
    logic [1:0]       fifo_cnt_q, fifo_cnt_d;
    logic             done_q, done_d;

    logic advance;
    logic accept;
    logic push;
    logic fifo_full;
    logic fifo_nonempty;

    assign fifo_full     = (fifo_cnt_q == 2'd2);
    assign fifo_nonempty = (fifo_cnt_q != 2'd0);

    // The whole pipeline moves together; only a refused output holds it.
    assign advance   = !(v_q[LAT-1] && !out_ready);
    assign req_ready = (state_q == ST_RUN) && advance && fifo_nonempty && !flush;
    assign accept    = req_valid && req_ready;
    assign rnd_ready = !fifo_full;
    assign push      = rnd_valid && rnd_ready;

    assign sbox_en   = advance;
    assign sbox_r    = rp_q[RSTAGE-1];
    assign out_valid = v_q[LAT-1];
    assign done      = done_q;
    assign busy      = (v_q != '0) || (state_q != ST_IDLE);

    // Randomness FIFO: a pushed word is only visible from the next cycle.
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        if (push) begin
            fifo_mem_d[fifo_wr_q] = rnd_in;
        end
        fifo_wr_d  = fifo_wr_q ^ push;
        fifo_rd_d  = fifo_rd_q ^ accept;
        fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, accept};
    end

    always_comb begin
        v_d = v_q;
        if (advance) begin
            v_d = {v_q[LAT-2:0], accept};
        end
    end

    // Words move with their own evaluation only, so bubbles leave sbox_r untouched.
    always_comb begin
        rp_d = rp_q;
        if (accept) begin
            rp_d[0] = fifo_mem_q[fifo_rd_q];
        end
        for (int k = 1; k < RSTAGE; k++) begin
            if (advance && v_q[k-1]) begin
                rp_d[k] = rp_q[k-1];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_full) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (v_d == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            v_q        <= '0;
            fifo_rd_q  <= 1'b0;
            fifo_wr_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
            done_q     <= 1'b0;
            for (int k = 0; k < RSTAGE; k++) begin
                rp_q[k] <= '0;
            end
            for (int k = 0; k < 2; k++) begin
                fifo_mem_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            v_q        <= v_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_cnt_q <= fifo_cnt_d;
            done_q     <= done_d;
            rp_q       <= rp_d;
            fifo_mem_q <= fifo_mem_d;
        end
    end

`ifdef MASKED_SBOX_SEQ_CNT_EN
    logic [15:0] eval_cnt_q, eval_cnt_d;

    always_comb begin
        eval_cnt_d = eval_cnt_q;
        if (v_q[LAT-1] && out_ready) begin
            eval_cnt_d = eval_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eval_cnt_q <= 16'd0;
        end else begin
            eval_cnt_q <= eval_cnt_d;
        end
    end

    assign eval_cnt = eval_cnt_q;
`endif

endmodule

// File: tb/tb_masked_sbox_seq.sv
// Directed self-checking bench for masked_sbox_seq (LAT=4, RSTAGE=1, RND_W=6).
module tb_masked_sbox_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] rnd_in;
    logic       rnd_valid;
    logic       rnd_ready;
    logic       sbox_en;
    logic [5:0] sbox_r;
    logic       out_valid;
    logic       out_ready;
    logic       flush;
    logic       done;
    logic       busy;
`ifdef MASKED_SBOX_SEQ_CNT_EN
    logic [15:0] eval_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    masked_sbox_seq #(.LAT(4), .RSTAGE(1), .RND_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rnd_in    (rnd_in),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .sbox_en   (sbox_en),
        .sbox_r    (sbox_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flush     (flush),
        .done      (done),
        .busy      (busy)
`ifdef MASKED_SBOX_SEQ_CNT_EN
        ,
        .eval_cnt  (eval_cnt)
`endif
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Reset, push two words, and step until the sequencer is in RUN.
    task automatic prime(input logic [5:0] a, input logic [5:0] b);
        rst_n = 1'b0; req_valid = 1'b0; rnd_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        nxt();
        rst_n = 1'b1; rnd_valid = 1'b1; rnd_in = a;
        nxt();
        rnd_in = b;
        nxt();
        rnd_valid = 1'b0;
        nxt();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rnd_valid = 1'b0; rnd_in = '0;
        flush = 1'b0; out_ready = 1'b1;
        nxt();
        nxt();
        n_tests++;
        if ({req_ready, rnd_ready, sbox_en, out_valid, done, busy} !== 6'b011000) begin
            n_fail++;
            $display("FAIL reset_flags got %b exp 011000", {req_ready, rnd_ready, sbox_en, out_valid, done, busy});
        end
        n_tests++;
        if (sbox_r !== 6'h00) begin
            n_fail++;
            $display("FAIL reset_sbox_r got %h exp 00", sbox_r);
        end
`ifdef MASKED_SBOX_SEQ_CNT_EN
        n_tests++;
        if (eval_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_eval_cnt got %h exp 0000", eval_cnt);
        end
`endif
        $display("[TB] test_reset done");
    endtask

    task automatic test_prime();
        rst_n = 1'b1; rnd_valid = 1'b1; rnd_in = 6'h01;
        #1;
        n_tests++;
        if (rnd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL prime_rnd_ready_empty got %b exp 1", rnd_ready);
        end
        nxt();
        rnd_in = 6'h02;
        nxt();
        rnd_valid = 1'b0;
        #1;
        n_tests++;
        if ({rnd_ready, req_ready, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL prime_full_idle got %b exp 000", {rnd_ready, req_ready, busy});
        end
        nxt();
        #1;
        n_tests++;
        if ({req_ready, busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL prime_run got %b exp 11", {req_ready, busy});
        end
        $display("[TB] test_prime done");
    endtask

    task automatic test_single();
        prime(6'h15, 6'h2A);
        req_valid = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_req_ready got %b exp 1", req_ready);
        end
        nxt();
        req_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            #1;
            n_tests++;
            if (sbox_r !== 6'h15) begin
                n_fail++;
                $display("FAIL single_sbox_r t+%0d got %h exp 15", i, sbox_r);
            end
            n_tests++;
            if (out_valid !== (i == 4) || done !== 1'b0) begin
                n_fail++;
                $display("FAIL single_out t+%0d got ov=%b done=%b exp ov=%b done=0", i, out_valid, done, (i == 4));
            end
            nxt();
        end
`ifdef MASKED_SBOX_SEQ_CNT_EN
        n_tests++;
        if (eval_cnt !== 16'h0001) begin
            n_fail++;
            $display("FAIL single_eval_cnt got %h exp 0001", eval_cnt);
        end
`endif
        $display("[TB] test_single done");
    endtask

    task automatic test_stall();
        logic [5:0] exp_r;
        logic [5:0] pop_w;
        logic [5:0] nword;
        logic       exp_acc;
        logic       pushed;
        prime(6'h01, 6'h02);
        exp_r = 6'h00; pop_w = 6'h01; nword = 6'h03;
        req_valid = 1'b1; rnd_valid = 1'b1; rnd_in = nword;
        for (int i = 0; i < 12; i++) begin
            exp_acc   = (i < 4) || (i > 6);
            out_ready = exp_acc;
            #1;
            n_tests++;
            if (req_ready !== exp_acc || sbox_en !== exp_acc) begin
                n_fail++;
                $display("FAIL stall_en c%0d got rdy=%b en=%b exp %b", i, req_ready, sbox_en, exp_acc);
            end
            n_tests++;
            if (out_valid !== (i >= 4)) begin
                n_fail++;
                $display("FAIL stall_out_valid c%0d got %b exp %b", i, out_valid, (i >= 4));
            end
            n_tests++;
            if (sbox_r !== exp_r) begin
                n_fail++;
                $display("FAIL stall_sbox_r c%0d got %h exp %h", i, sbox_r, exp_r);
            end
            pushed = rnd_valid && rnd_ready;
            nxt();
            if (exp_acc) begin
                exp_r = pop_w;
                pop_w = pop_w + 6'd1;
            end
            if (pushed) begin
                nword  = nword + 6'd1;
                rnd_in = nword;
            end
        end
        req_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) nxt();
        $display("[TB] test_stall done");
    endtask

    task automatic test_prng_stall();
        logic [5:0] exp_r;
        prime(6'h0A, 6'h0B);
        req_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            exp_r = (i == 0) ? 6'h00 : ((i == 1) ? 6'h0A : 6'h0B);
            #1;
            n_tests++;
            if (req_ready !== (i < 2)) begin
                n_fail++;
                $display("FAIL prng_req_ready c%0d got %b exp %b", i, req_ready, (i < 2));
            end
            n_tests++;
            if (sbox_r !== exp_r || out_valid !== (i == 4 || i == 5)) begin
                n_fail++;
                $display("FAIL prng_bubble c%0d got r=%h ov=%b exp r=%h ov=%b", i, sbox_r, out_valid, exp_r, (i == 4 || i == 5));
            end
            nxt();
        end
        req_valid = 1'b0;
        $display("[TB] test_prng_stall done");
    endtask

    task automatic test_flush();
        prime(6'h11, 6'h12);
        rnd_valid = 1'b1; rnd_in = 6'h13; req_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            flush = (i == 3);
            #1;
            n_tests++;
            if (req_ready !== (i < 3 || i == 8)) begin
                n_fail++;
                $display("FAIL flush_req_ready c%0d got %b exp %b", i, req_ready, (i < 3 || i == 8));
            end
            n_tests++;
            if (out_valid !== (i >= 4 && i <= 6)) begin
                n_fail++;
                $display("FAIL flush_out_valid c%0d got %b exp %b", i, out_valid, (i >= 4 && i <= 6));
            end
            n_tests++;
            if (done !== (i == 7) || busy !== (i != 7)) begin
                n_fail++;
                $display("FAIL flush_done c%0d got done=%b busy=%b exp done=%b busy=%b", i, done, busy, (i == 7), (i != 7));
            end
            nxt();
        end
        flush = 1'b0; req_valid = 1'b0; rnd_valid = 1'b0;
        $display("[TB] test_flush done");
    endtask

    task automatic test_reset_midop();
        prime(6'h21, 6'h22);
        rnd_valid = 1'b1; rnd_in = 6'h23; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) nxt();
        req_valid = 1'b0; rnd_valid = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b1 || sbox_r !== 6'h23) begin
            n_fail++;
            $display("FAIL midop_inflight got busy=%b r=%h exp busy=1 r=23", busy, sbox_r);
        end
        rst_n = 1'b0;
        nxt();
        n_tests++;
        if ({req_ready, rnd_ready, sbox_en, out_valid, done, busy} !== 6'b011000 || sbox_r !== 6'h00) begin
            n_fail++;
            $display("FAIL midop_reset got %b r=%h exp 011000 r=00", {req_ready, rnd_ready, sbox_en, out_valid, done, busy}, sbox_r);
        end
`ifdef MASKED_SBOX_SEQ_CNT_EN
        n_tests++;
        if (eval_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL midop_eval_cnt got %h exp 0000", eval_cnt);
        end
`endif
        rst_n = 1'b1; rnd_valid = 1'b1; rnd_in = 6'h30;
        nxt();
        rnd_valid = 1'b0;
        nxt();
        nxt();
        n_tests++;
        if (req_ready !== 1'b0 || rnd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_fifo_cleared got rdy=%b rnd_rdy=%b exp 0 1", req_ready, rnd_ready);
        end
        rnd_valid = 1'b1; rnd_in = 6'h31;
        nxt();
        rnd_valid = 1'b0;
        nxt();
        req_valid = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_rerun got %b exp 1", req_ready);
        end
        nxt();
        req_valid = 1'b0;
        n_tests++;
        if (sbox_r !== 6'h30) begin
            n_fail++;
            $display("FAIL midop_first_word got %h exp 30", sbox_r);
        end
        $display("[TB] test_reset_midop done");
    endtask

    initial begin
        test_reset();
        test_prime();
        test_single();
        test_stall();
        test_prng_stall();
        test_flush();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
